// File: rtl/aqed_pkg.sv
// Shared types and width helpers for the A-QED double-buffer checker.
package aqed_pkg;

  typedef enum logic [1:0] {
    AQ_IDLE,
    AQ_ARMED,
    AQ_INFLIGHT,
    AQ_DONE
  } aq_state_e;

  // Width of a counter that must hold 0..num_banks inclusive.
  function automatic int unsigned occ_width(input int unsigned num_banks);
    return $clog2(num_banks + 1);
  endfunction

  function automatic int unsigned lat_width(input int unsigned read_lat);
    return $clog2(read_lat + 1);
  endfunction

endpackage

// File: rtl/aqed_win_counter.sv
// Slot counter within one bank window; wraps at depth_q-1 and flags the wrap.
module aqed_win_counter #(
  parameter int unsigned DEPTH_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   inc,
  input  logic [DEPTH_WIDTH-1:0] depth_q,
  output logic [DEPTH_WIDTH-1:0] cnt,
  output logic                   wrap
);

  logic [DEPTH_WIDTH-1:0] cnt_q;
  logic                   last;

  // depth_q is never zero, the owner clamps it to at least one.
  assign last = (cnt_q == depth_q - DEPTH_WIDTH'(1));
  assign wrap = inc & last;
  assign cnt  = cnt_q;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt_q <= '0;
    end else if (inc) begin
      cnt_q <= last ? '0 : cnt_q + DEPTH_WIDTH'(1);
    end
  end

endmodule

// File: rtl/aqed_db_checker.sv
// Single-action A-QED checker: captures one write, tracks it through the bank
// rotation to its matching read, and compares returned data after READ_LAT.
module aqed_db_checker
  import aqed_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned DEPTH_WIDTH = 16,
  parameter int unsigned NUM_BANKS   = 2,
  parameter int unsigned READ_LAT    = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clk_en,
  input  logic                   flush,
  input  logic [DEPTH_WIDTH-1:0] depth,
  input  logic                   wen_in,
  input  logic                   ren_in,
  input  logic [DATA_WIDTH-1:0]  data_in,
  input  logic [DATA_WIDTH-1:0]  data_out,
  input  logic                   valid_out,
  input  logic                   capture_sel,
  output logic                   wen_allow,
  output logic                   ren_allow,
  output logic                   qed_done,
  output logic                   qed_check
);

  localparam int unsigned OccW = occ_width(NUM_BANKS);
  localparam int unsigned LatW = lat_width(READ_LAT);

  logic [DEPTH_WIDTH-1:0] depth_q, depth_eff;
  logic                   load_pend_q;
  logic [OccW-1:0]        occ_q, cap_dist_q, cap_dist_now;
  logic [LatW-1:0]        lat_cnt_q;
  logic [DATA_WIDTH-1:0]  cap_data_q;
  logic [DEPTH_WIDTH-1:0] cap_slot_q, wcnt, rcnt;
  logic                   wr_acc, rd_acc, w_wrap, r_wrap;
  logic                   qed_done_q, qed_check_q;
  aq_state_e              state_q;

  assign depth_eff = (depth == '0) ? DEPTH_WIDTH'(1) : depth;

  assign wen_allow = (occ_q < OccW'(NUM_BANKS));
  assign ren_allow = (occ_q != '0);
  assign wr_acc    = clk_en & wen_in & wen_allow;
  assign rd_acc    = clk_en & ren_in & ren_allow;
  assign qed_done  = qed_done_q;
  assign qed_check = qed_check_q;

  // Bank distance from the read pointer, seen after this cycle's read wrap.
  assign cap_dist_now = occ_q - OccW'(r_wrap);

  aqed_win_counter #(.DEPTH_WIDTH(DEPTH_WIDTH)) u_wr_cnt (
    .clk    (clk),
    .reset  (reset),
    .clear  (flush),
    .inc    (wr_acc),
    .depth_q(depth_q),
    .cnt    (wcnt),
    .wrap   (w_wrap)
  );

  aqed_win_counter #(.DEPTH_WIDTH(DEPTH_WIDTH)) u_rd_cnt (
    .clk    (clk),
    .reset  (reset),
    .clear  (flush),
    .inc    (rd_acc),
    .depth_q(depth_q),
    .cnt    (rcnt),
    .wrap   (r_wrap)
  );

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      depth_q     <= depth_eff;
      load_pend_q <= 1'b1;
    end else if (clk_en && load_pend_q) begin
      depth_q     <= depth_eff;
      load_pend_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      occ_q <= '0;
    end else if (clk_en) begin
      if (w_wrap && !r_wrap) begin
        occ_q <= occ_q + OccW'(1);
      end else if (r_wrap && !w_wrap) begin
        occ_q <= occ_q - OccW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= AQ_IDLE;
      cap_data_q  <= '0;
      cap_slot_q  <= '0;
      cap_dist_q  <= '0;
      lat_cnt_q   <= '0;
      qed_done_q  <= 1'b0;
      qed_check_q <= 1'b0;
    end else if (flush) begin
      if (state_q != AQ_DONE) begin
        state_q <= AQ_IDLE;
      end
    end else if (clk_en) begin
      case (state_q)
        AQ_IDLE: begin
          if (wr_acc && capture_sel) begin
            cap_data_q <= data_in;
            cap_slot_q <= wcnt;
            cap_dist_q <= cap_dist_now;
            if (cap_dist_now == '0 && rd_acc && rcnt == wcnt) begin
              state_q   <= AQ_INFLIGHT;
              lat_cnt_q <= LatW'(READ_LAT - 1);
            end else begin
              state_q <= AQ_ARMED;
            end
          end
        end
        AQ_ARMED: begin
          if (cap_dist_q == '0 && rd_acc && rcnt == cap_slot_q) begin
            state_q   <= AQ_INFLIGHT;
            lat_cnt_q <= LatW'(READ_LAT - 1);
          end else if (r_wrap) begin
            cap_dist_q <= cap_dist_q - OccW'(1);
          end
        end
        AQ_INFLIGHT: begin
          if (lat_cnt_q == '0) begin
            state_q     <= AQ_DONE;
            qed_done_q  <= 1'b1;
            qed_check_q <= valid_out && (data_out == cap_data_q);
          end else begin
            lat_cnt_q <= lat_cnt_q - LatW'(1);
          end
        end
        AQ_DONE: ;
        default: state_q <= AQ_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aqed_db_checker.sv
// Randomised and directed bench for aqed_db_checker against a FIFO-order model.
module tb_aqed_db_checker;

  localparam int unsigned DW = 16;
  localparam int unsigned PW = 16;
  localparam int unsigned NB = 2;
  localparam int unsigned RL = 1;
  localparam int          D  = 4;

  logic          clk = 1'b0;
  logic          reset, clk_en, flush, wen_in, ren_in, valid_out, capture_sel;
  logic [PW-1:0] depth;
  logic [DW-1:0] data_in, data_out;
  logic          wen_allow, ren_allow, qed_done, qed_check;

  int n_cmp = 0;
  int n_err = 0;

  // Model: absolute write/read indices since the last clear; the k-th write is
  // returned by the k-th read because banks are consumed in fill order.
  int            m_w, m_r, m_st, m_cap_k, m_lat;
  logic [DW-1:0] m_cap_data;
  bit            m_done, m_check;
  logic [DW-1:0] mem_q[$];
  logic [DW-1:0] last_rd;
  bit            last_racc;

  aqed_db_checker #(
    .DATA_WIDTH (DW),
    .DEPTH_WIDTH(PW),
    .NUM_BANKS  (NB),
    .READ_LAT   (RL)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .clk_en     (clk_en),
    .flush      (flush),
    .depth      (depth),
    .wen_in     (wen_in),
    .ren_in     (ren_in),
    .data_in    (data_in),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .capture_sel(capture_sel),
    .wen_allow  (wen_allow),
    .ren_allow  (ren_allow),
    .qed_done   (qed_done),
    .qed_check  (qed_check)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int m_occ();
    return m_w / D - m_r / D;
  endfunction

  task automatic do_reset();
    reset = 1'b1; clk_en = 1'b0; flush = 1'b0; wen_in = 1'b0; ren_in = 1'b0;
    data_in = '0; data_out = '0; valid_out = 1'b0; capture_sel = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    m_w = 0; m_r = 0; m_st = 0; m_cap_k = 0; m_lat = 0;
    m_cap_data = '0; m_done = 0; m_check = 0;
    mem_q.delete();
  endtask

  // Called just after a rising edge; drives one cycle, checks, advances the model.
  task automatic cycle(input bit en, input bit fl, input bit we, input bit re,
                       input logic [DW-1:0] din, input bit sel,
                       input bit vo, input logic [DW-1:0] dout);
    bit wacc, racc;
    clk_en = en; flush = fl; wen_in = we; ren_in = re; data_in = din;
    capture_sel = sel; valid_out = vo; data_out = dout;
    #3;
    chk("wen_allow", wen_allow, (m_occ() < NB) ? 1 : 0);
    chk("ren_allow", ren_allow, (m_occ() > 0) ? 1 : 0);
    chk("qed_done", qed_done, m_done);
    chk("qed_check", qed_check, m_check);
    wacc = en && we && (m_occ() < NB);
    racc = en && re && (m_occ() > 0);
    last_racc = 0;
    if (fl) begin
      m_w = 0; m_r = 0;
      mem_q.delete();
      if (m_st != 3) m_st = 0;
    end else if (en) begin
      case (m_st)
        0: if (wacc && sel) begin
          m_cap_k = m_w; m_cap_data = din;
          if (racc && m_r == m_w) begin m_st = 2; m_lat = RL - 1; end
          else m_st = 1;
        end
        1: if (racc && m_r == m_cap_k) begin m_st = 2; m_lat = RL - 1; end
        2: if (m_lat == 0) begin
          m_st = 3; m_done = 1; m_check = vo && (dout == m_cap_data);
        end else m_lat--;
        default: ;
      endcase
      if (wacc) begin mem_q.push_back(din); m_w++; end
      if (racc) begin
        last_racc = 1;
        last_rd = (mem_q.size() > 0) ? mem_q.pop_front() : '0;
        m_r++;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [DW-1:0] d, input bit sel);
    cycle(1, 0, 1, 0, d, sel, 0, '0);
  endtask

  task automatic rd();
    cycle(1, 0, 0, 1, '0, 0, 0, '0);
  endtask

  // Capture slot 2 of bank 0, read slots 0..2, present the response.
  task automatic run_slot2(input bit vo, input logic [DW-1:0] dout, input bit exp_chk);
    do_reset();
    for (int i = 0; i < 4; i++) wr((i == 2) ? 16'hBEEF : 16'h1000 + 16'(i), i == 2);
    for (int i = 0; i < 3; i++) rd();
    cycle(1, 0, 0, 0, '0, 0, vo, dout);
    chk("slot2_done", qed_done, 1);
    chk("slot2_check", qed_check, exp_chk);
  endtask

  initial begin
    bit            pend, vo, en, fl, we, re, sel;
    logic [DW-1:0] pend_d, dout;
    depth = PW'(D);

    // Reset values and clock-enable freeze.
    do_reset();
    chk("rst_wen_allow", wen_allow, 1);
    chk("rst_ren_allow", ren_allow, 0);
    chk("rst_qed_done", qed_done, 0);
    chk("rst_qed_check", qed_check, 0);
    for (int i = 0; i < 5; i++) cycle(0, 0, 1, 1, 16'h5555, 1, 1, 16'h5555);
    chk("frz_wen_allow", wen_allow, 1);
    chk("frz_ren_allow", ren_allow, 0);

    // Fill both banks; a ninth write must not move the write slot.
    for (int i = 0; i < 8; i++) wr(16'h0100 + 16'(i), 0);
    chk("full_wen_allow", wen_allow, 0);
    chk("full_ren_allow", ren_allow, 1);
    wr(16'h01FF, 0);
    for (int i = 0; i < 4; i++) rd();
    chk("drain1_wen_allow", wen_allow, 1);
    wr(16'hA5A5, 1);
    for (int i = 0; i < 3; i++) wr(16'h0200 + 16'(i), 0);
    for (int i = 0; i < 5; i++) rd();
    cycle(1, 0, 0, 0, '0, 0, 1, 16'hA5A5);
    chk("slot0_after9_done", qed_done, 1);
    chk("slot0_after9_check", qed_check, 1);

    // Matching, corrupted and invalid responses; flush after completion.
    run_slot2(1, 16'hBEEF, 1);
    cycle(1, 1, 0, 0, '0, 0, 0, '0);
    chk("flush_done_kept", qed_done, 1);
    chk("flush_check_kept", qed_check, 1);
    run_slot2(1, 16'hBEEE, 0);
    run_slot2(0, 16'hBEEF, 0);

    // Capture one bank ahead of the read pointer.
    do_reset();
    for (int i = 0; i < 4; i++) wr(16'h3000 + 16'(i), 0);
    for (int i = 0; i < 4; i++) wr((i == 1) ? 16'hC0DE : 16'h3100 + 16'(i), i == 1);
    rd(); rd();
    cycle(1, 0, 0, 0, '0, 0, 1, 16'hC0DE);
    chk("dist1_early_done", qed_done, 0);
    for (int i = 0; i < 4; i++) rd();
    cycle(1, 0, 0, 0, '0, 0, 1, 16'hC0DE);
    chk("dist1_done", qed_done, 1);
    chk("dist1_check", qed_check, 1);

    // Flush while armed abandons the capture.
    do_reset();
    wr(16'h7777, 1);
    cycle(1, 1, 0, 0, '0, 0, 0, '0);
    chk("flush_armed_ren_allow", ren_allow, 0);
    chk("flush_armed_done", qed_done, 0);
    for (int i = 0; i < 4; i++) wr(16'h7777, 0);
    for (int i = 0; i < 4; i++) cycle(1, 0, 0, 1, '0, 0, 1, 16'h7777);
    cycle(1, 0, 0, 0, '0, 0, 1, 16'h7777);
    chk("flush_armed_no_done", qed_done, 0);

    // Random traffic with an emulated memory core behind the checker.
    for (int run = 0; run < 30; run++) begin
      do_reset();
      pend = 0; pend_d = '0;
      for (int c = 0; c < 80; c++) begin
        en  = ($urandom % 10) != 0;
        fl  = ($urandom % 60) == 0;
        we  = ($urandom % 3) != 0;
        re  = ($urandom % 2) != 0;
        sel = !re && (($urandom % 6) == 0);
        if (pend) begin
          vo   = ($urandom % 8) != 0;
          dout = (($urandom % 4) == 0) ? pend_d ^ (16'h1 << ($urandom % 16)) : pend_d;
        end else begin
          vo   = 0;
          dout = DW'($urandom);
        end
        cycle(en, fl, we, re, DW'($urandom), sel, vo, dout);
        if (fl || en) pend = 0;
        if (last_racc) begin pend = 1; pend_d = last_rd; end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/aqed_db_checker.md
# aqed_db_checker

Parametrised single-action A-QED consistency checker and bank-window tracker for the double-buffered memory core. It sits beside the memory core in the formal top and generalises the fixed two-bank read/write window counting to NUM_BANKS banks of run-time depth. It also exports write/read admission signals for use as formal constraints. It captures one freely chosen write, follows it through the bank rotation to the matching read, and checks the returned data after a fixed READ_LAT.

## Interface
- DATA_WIDTH, 16, data bus width
- DEPTH_WIDTH, 16, width of depth and slot counters
- NUM_BANKS, 2, number of buffer banks (≥2)
- READ_LAT, 1, cycles from accepted read to valid_out (≥1)
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high; clears all state
- clk_en  in  1  global enable; when low all state holds
- flush  in  1  synchronous soft clear (see Operation)
- depth  in  DEPTH_WIDTH  words per bank, latched into depth_q
- wen_in  in  1  write request
- ren_in  in  1  read request
- data_in  in  DATA_WIDTH  write data
- data_out  in  DATA_WIDTH  memory core read data
- valid_out  in  1  memory core read-valid
- capture_sel  in  1  free input; a high level on an accepted write selects that write
- wen_allow  out  1  write admissible: occ < NUM_BANKS
- ren_allow  out  1  read admissible: occ > 0
- qed_done  out  1  sticky; check has completed
- qed_check  out  1  sticky; check result, 1 = match

## Operation
- depth_q is loaded from depth on reset, on flush, and on the first clk_en cycle after either. depth_q = 0 is treated as 1.
- Accepted write: wr_acc = clk_en & wen_in & wen_allow. Accepted read: rd_acc = clk_en & ren_in & ren_allow. Requests that are not accepted are ignored and not counted.
- wcnt/rcnt count accepted ops, 0..depth_q−1. On an accepted op at depth_q−1 the counter wraps to 0 and pulses w_wrap/r_wrap.
- Bank occupancy occ is 0..NUM_BANKS: +1 on w_wrap, −1 on r_wrap, unchanged when both occur.
- Checker FSM states:
  - IDLE → ARMED on wr_acc & capture_sel. On that transition latch cap_data = data_in, cap_slot = wcnt, and cap_dist = occ − (r_wrap ? 1 : 0).
  - ARMED: each r_wrap decrements cap_dist. When cap_dist == 0 and rd_acc with rcnt == cap_slot occur, go to INFLIGHT and load lat_cnt = READ_LAT−1.
  - INFLIGHT: lat_cnt decrements on clk_en cycles. At lat_cnt == 0 go to DONE and set qed_check = valid_out & (data_out == cap_data).
  - DONE: terminal until reset; qed_done = 1.
- Only one capture per run. capture_sel is ignored outside IDLE.
- The capturing write and the matching read may occur in the same cycle only if cap_dist == 0 and rcnt == wcnt. In that case IDLE goes directly to INFLIGHT.
- flush: clears wcnt, rcnt and occ, and returns IDLE/ARMED/INFLIGHT to IDLE. DONE, qed_done and qed_check are kept.
- reset mid-operation: all state returns to reset values on the next edge.

## Timing
- Reset values: wen_allow = 1, ren_allow = 0, qed_done = 0, qed_check = 0. Internal reset values: occ = 0, FSM = IDLE.
- wen_allow and ren_allow are combinational from occ and valid in the same cycle as the request. There is no other combinational path from inputs to outputs.
- qed_done and qed_check rise together on the edge at which lat_cnt == 0 is sampled in INFLIGHT. This is READ_LAT edges after the matching rd_acc.
- clk_en low freezes counters, occ, the FSM and lat_cnt. Latency is therefore counted in enabled cycles.
- Widths: occ is $clog2(NUM_BANKS+1) bits. cap_dist has the same width as occ. lat_cnt is $clog2(READ_LAT+1) bits.

## Structure
- Package aqed_pkg holds:
  - the FSM enum: AQ_IDLE, AQ_ARMED, AQ_INFLIGHT, AQ_DONE;
  - localparam helpers for the occ and lat widths.
- Sub-module aqed_win_counter (parameter DEPTH_WIDTH; inputs inc and depth_q; outputs cnt and wrap) is instantiated twice, once for writes and once for reads.
- The top of the checker holds the occ register, the FSM and the capture registers.

## Test plan
All scenarios use DEPTH=4, NUM_BANKS=2, READ_LAT=1.
- After reset: wen_allow = 1, ren_allow = 0, qed_done = 0. Hold clk_en = 0 for 5 cycles → no state change.
- Write 8 words with ren_in low → occ = 2 and wen_allow = 0 after the 8th write. A 9th wen_in is ignored, with wcnt still 0.
- Capture write #2 (slot 2, cap_dist 0, data 0xBEEF). Read slots 0, 1, 2, then drive valid_out = 1, data_out = 0xBEEF one cycle after the third read → qed_done = 1, qed_check = 1.
- Same setup with data_out = 0xBEEE, or with valid_out = 0 at the check cycle → qed_done = 1, qed_check = 0.
- Capture slot 1 of bank 1 while bank 0 is full (cap_dist = 1). Reads of slot 1 in bank 0 do not trigger; the read of slot 1 after r_wrap triggers INFLIGHT.
- Flush in ARMED → FSM returns to IDLE, occ = 0, qed_done stays 0. Flush after DONE → qed_done and qed_check retained.
